// File: rtl/oam_dma_ctrl.sv
// OAM DMA controller: a CPU write to the start register copies DMA_LEN bytes
// from page {src,00} into OAM, one READ/WRITE pair per byte.
`timescale 1ns/1ps
module oam_dma_ctrl #(
    parameter int          DMA_LEN   = 160,
    parameter logic [15:0] REG_ADDR  = 16'hFF46,
    parameter logic [15:0] DEST_BASE = 16'hFE00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        cpu_we,
    input  logic        cpu_re,
    output logic [7:0]  cpu_rdata,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        mem_we,
    output logic        mem_re,
    input  logic [7:0]  mem_rdata,
    output logic        dma_active
);

    typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

    localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

    state_t     state, state_next;
    logic [7:0] idx, idx_next;
    logic [7:0] src, src_next;
    logic [7:0] byte_buf, byte_buf_next;
    logic       reg_hit;
    logic       reg_write;
    logic [7:0] src_eff;

    assign reg_hit    = (cpu_addr == REG_ADDR);
    assign reg_write  = reg_hit && cpu_we;
    // Source pages E0-FF alias onto C0-DF.
    assign src_eff    = (src >= 8'hE0) ? (src - 8'h20) : src;
    assign dma_active = (state != IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            idx      <= 8'h00;
            src      <= 8'h00;
            byte_buf <= 8'h00;
        end else begin
            state    <= state_next;
            idx      <= idx_next;
            src      <= src_next;
            byte_buf <= byte_buf_next;
        end
    end

    always_comb begin
        state_next    = state;
        idx_next      = idx;
        src_next      = src;
        byte_buf_next = byte_buf;
        case (state)
            IDLE: ;
            READ: begin
                byte_buf_next = mem_rdata;
                state_next    = WRITE;
            end
            WRITE: begin
                if (idx == LAST_IDX) begin
                    state_next = IDLE;
                end else begin
                    idx_next   = idx + 8'd1;
                    state_next = READ;
                end
            end
            default: state_next = IDLE;
        endcase
        // A start-register write wins over everything, including the final WRITE.
        if (reg_write) begin
            src_next   = cpu_wdata;
            idx_next   = 8'h00;
            state_next = READ;
        end
    end

    always_comb begin
        mem_addr  = 16'h0000;
        mem_wdata = 8'h00;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        case (state)
            IDLE: begin
                if (!reg_hit) begin
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                    mem_we    = cpu_we;
                    mem_re    = cpu_re;
                end
            end
            READ: begin
                mem_re   = 1'b1;
                mem_addr = {src_eff, idx};
            end
            WRITE: begin
                mem_we    = 1'b1;
                mem_addr  = DEST_BASE + {8'h00, idx};
                mem_wdata = byte_buf;
            end
            default: ;
        endcase
        // Reset silences the bus immediately, even before the state register settles.
        if (!reset) begin
            mem_we = 1'b0;
            mem_re = 1'b0;
        end
    end

    always_comb begin
        cpu_rdata = 8'hFF;
        if (reg_hit && cpu_re)
            cpu_rdata = src;
        else if (state == IDLE && !reg_hit)
            cpu_rdata = mem_rdata;
    end

endmodule
